// File: rtl/multdiv_engine_if.sv
// ---------------------------------------------------------------------------
// multdiv_engine_if
// Bundles the operand/start/result signals exchanged between the pipeline's
// multDiv assert logic (master) and the iterative multiply/divide unit (slave).
//
// Signals:
//   data_operandA  [31:0]  multiplicand or dividend (master -> slave)
//   data_operandB  [31:0]  multiplier or divisor    (master -> slave)
//   ctrl_MULT              one-cycle start-multiply pulse
//   ctrl_DIV               one-cycle start-divide pulse
//   data_result    [31:0]  registered result        (slave -> master)
//   data_exception         overflow / divide-by-zero flag
//   data_resultRDY         one-cycle completion strobe
//   busy                   unit is working, hold the execute stage
// ---------------------------------------------------------------------------
interface multdiv_engine_if;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/multdiv_engine.sv
// ---------------------------------------------------------------------------
// multdiv_engine
// Iterative signed 32-bit multiply/divide unit. A start pulse in IDLE latches
// the operands; the unit then runs a Booth multiply or a non-restoring divide
// on magnitudes, and returns a one-cycle data_resultRDY strobe together with
// the registered result and exception flag.
//
// Ports:
//   clock   system clock, rising edge
//   reset   asynchronous, active-high; clears all state
//   bus     multdiv_engine_if.slave (operands, start pulses, result, busy)
//
// Configuration macro:
//   MULTDIV_BOOTH4_EN  defined   -> radix-4 modified Booth multiply, 16 steps
//                      undefined -> radix-2 Booth multiply, 32 steps
//   Divide and all results are identical in both builds.
// ---------------------------------------------------------------------------
module multdiv_engine (
   input  logic             clock,
   input  logic             reset,
   multdiv_engine_if.slave  bus
);

`ifdef MULTDIV_BOOTH4_EN
   localparam int MUL_STEPS = 16;
   localparam int MUL_SHIFT = 2;
`else
   localparam int MUL_STEPS = 32;
   localparam int MUL_SHIFT = 1;
`endif
   localparam logic [4:0] LAST_MUL = 5'(MUL_STEPS - 1);
   localparam logic [4:0] LAST_DIV = 5'd31;

   typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

   state_t state, state_next;

   // Shared working registers: Booth uses {acc, q, qm1} with mcand as the
   // multiplicand; divide uses acc as the signed partial remainder, q as the
   // dividend/quotient shift register and mcand as |divisor|.
   logic [33:0] acc;
   logic [31:0] q;
   logic [31:0] mcand;
   logic        qm1;
   logic [4:0]  count;
   logic        op_div;
   logic        div_zero;
   logic        neg_res;

   logic [31:0] result_reg;
   logic        exception_reg;
   logic        rdy_reg;

   logic        busy;
   logic [31:0] fin_result;
   logic        fin_exception;

   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic        b_zero;

   logic [33:0]        m_ext;
   logic [33:0]        booth_sum;
   logic signed [66:0] booth_shift;

   logic [33:0] d_ext;
   logic [33:0] rem_shift;
   logic [33:0] rem_next;
   logic [31:0] quo_next;

   logic [63:0] product;
   logic        mul_ovf;
   logic [31:0] div_quo;
   logic        div_ovf;

   // Magnitudes are taken as unsigned 32-bit values so that 0x80000000
   // keeps its correct magnitude of 2^31.
   assign a_abs  = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
   assign b_abs  = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;
   assign b_zero = (bus.data_operandB == 32'd0);

   // One Booth step: add/subtract the recoded multiple into the accumulator,
   // then arithmetic-shift the whole {acc, q, qm1} chain right. The 34-bit
   // accumulator leaves headroom for +/-2M and for the most negative
   // multiplicand.
   always_comb begin
      m_ext     = {{2{mcand[31]}}, mcand};
      booth_sum = acc;
`ifdef MULTDIV_BOOTH4_EN
      case ({q[1:0], qm1})
         3'b001, 3'b010: booth_sum = acc + m_ext;
         3'b011:         booth_sum = acc + (m_ext << 1);
         3'b100:         booth_sum = acc - (m_ext << 1);
         3'b101, 3'b110: booth_sum = acc - m_ext;
         default:        booth_sum = acc;
      endcase
`else
      case ({q[0], qm1})
         2'b01:   booth_sum = acc + m_ext;
         2'b10:   booth_sum = acc - m_ext;
         default: booth_sum = acc;
      endcase
`endif
      booth_shift = {booth_sum, q, qm1};
      booth_shift = booth_shift >>> MUL_SHIFT;
   end

   // One non-restoring divide step on magnitudes. The quotient bits come out
   // correct without a final fix-up; only the remainder would need
   // restoring, and it is discarded.
   always_comb begin
      d_ext     = {2'b00, mcand};
      rem_shift = {acc[32:0], q[31]};
      rem_next  = acc[33] ? (rem_shift + d_ext) : (rem_shift - d_ext);
      quo_next  = {q[30:0], ~rem_next[33]};
   end

   // Final result formatting. A positive quotient with bit 31 set can only
   // come from 0x80000000 / -1, which is the divide overflow case.
   always_comb begin
      product = {acc[31:0], q};
      mul_ovf = ~((&product[63:31]) | ~(|product[63:31]));
      div_quo = neg_res ? (32'd0 - q) : q;
      div_ovf = ~neg_res & q[31];
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next-state logic. Multiply wins when both start pulses arrive
   // together; a zero divisor skips straight to FIN.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.ctrl_MULT)     state_next = MULT;
            else if (bus.ctrl_DIV) state_next = b_zero ? FIN : DIV;
         end
         MULT:    if (count == LAST_MUL) state_next = FIN;
         DIV:     if (count == LAST_DIV) state_next = FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM output logic: busy flag and the value to be registered at FIN.
   always_comb begin
      busy          = (state != IDLE);
      fin_result    = product[31:0];
      fin_exception = mul_ovf;
      if (div_zero) begin
         fin_result    = 32'd0;
         fin_exception = 1'b1;
      end else if (op_div) begin
         fin_result    = div_quo;
         fin_exception = div_ovf;
      end
   end

   // Datapath: operand capture in IDLE and one iteration per cycle while
   // running. Start pulses outside IDLE are ignored.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc      <= '0;
         q        <= '0;
         mcand    <= '0;
         qm1      <= 1'b0;
         count    <= '0;
         op_div   <= 1'b0;
         div_zero <= 1'b0;
         neg_res  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.ctrl_MULT) begin
                  acc      <= '0;
                  q        <= bus.data_operandB;
                  mcand    <= bus.data_operandA;
                  qm1      <= 1'b0;
                  count    <= '0;
                  op_div   <= 1'b0;
                  div_zero <= 1'b0;
                  neg_res  <= 1'b0;
               end else if (bus.ctrl_DIV) begin
                  acc      <= '0;
                  q        <= a_abs;
                  mcand    <= b_abs;
                  qm1      <= 1'b0;
                  count    <= '0;
                  op_div   <= 1'b1;
                  div_zero <= b_zero;
                  neg_res  <= bus.data_operandA[31] ^ bus.data_operandB[31];
               end
            end
            MULT: begin
               acc   <= booth_shift[66:33];
               q     <= booth_shift[32:1];
               qm1   <= booth_shift[0];
               count <= count + 5'd1;
            end
            DIV: begin
               acc   <= rem_next;
               q     <= quo_next;
               count <= count + 5'd1;
            end
            default: ;
         endcase
      end
   end

   // Output registers: result and exception update only at FIN and hold
   // otherwise; the ready strobe is high for the single cycle after FIN.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         result_reg    <= '0;
         exception_reg <= 1'b0;
         rdy_reg       <= 1'b0;
      end else begin
         rdy_reg <= (state == FIN);
         if (state == FIN) begin
            result_reg    <= fin_result;
            exception_reg <= fin_exception;
         end
      end
   end

   assign bus.data_result    = result_reg;
   assign bus.data_exception = exception_reg;
   assign bus.data_resultRDY = rdy_reg;
   assign bus.busy           = busy;

endmodule

// File: tb/tb_multdiv_engine.sv
// ---------------------------------------------------------------------------
// tb_multdiv_engine
// Self-checking bench for multdiv_engine: a table of directed multiply and
// divide vectors with hand-computed results, plus hand-written sequences for
// a start pulse during a multiply, reset mid-operation and back-to-back
// operation.
// Define MULTDIV_BOOTH4_EN for both RTL and bench to check the radix-4 build.
// ---------------------------------------------------------------------------
module tb_multdiv_engine;

`ifdef MULTDIV_BOOTH4_EN
   localparam int LAT_MUL = 17;
`else
   localparam int LAT_MUL = 33;
`endif
   localparam int LAT_DIV = 33;
   localparam int LAT_DZ  = 1;

   typedef struct {
      logic        is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_result;
      logic        exp_exc;
      int          exp_lat;
   } vec_t;

   logic clock;
   logic reset;
   int   check_count;
   int   pass_count;

   multdiv_engine_if bus_if ();

   multdiv_engine dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got === exp) pass_count++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   // Issues one start pulse, then counts edges until RDY rises. Optionally
   // fires a ctrl_DIV pulse with a zero divisor at step disturb_at. Also
   // counts cycles where the old result did not hold before RDY.
   task automatic applyStimulus(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                input int disturb_at, output int lat, output int hold_bad);
      logic [31:0] prior;
      prior    = bus_if.data_result;
      hold_bad = 0;
      lat      = -1;
      bus_if.data_operandA = a;
      bus_if.data_operandB = b;
      bus_if.ctrl_MULT     = ~is_div;
      bus_if.ctrl_DIV      = is_div;
      @(posedge clock); #1;
      bus_if.ctrl_MULT = 1'b0;
      bus_if.ctrl_DIV  = 1'b0;
      checkOutput("busy_after_start", {31'd0, bus_if.busy}, 32'd1);
      for (int k = 1; k <= 100 && lat < 0; k++) begin
         if (k == disturb_at) begin
            bus_if.ctrl_DIV      = 1'b1;
            bus_if.data_operandB = 32'd0;
         end
         @(posedge clock); #1;
         bus_if.ctrl_DIV = 1'b0;
         if (bus_if.data_resultRDY) lat = k;
         else if (bus_if.data_result !== prior) hold_bad++;
      end
   endtask

   // Full check of one operation including the one-cycle RDY strobe.
   task automatic runVector(input string tag, input vec_t v, input int disturb_at);
      int lat, hold_bad;
      applyStimulus(v.is_div, v.a, v.b, disturb_at, lat, hold_bad);
      checkOutput({tag, "_latency"}, lat, v.exp_lat);
      checkOutput({tag, "_result"}, bus_if.data_result, v.exp_result);
      checkOutput({tag, "_exception"}, {31'd0, bus_if.data_exception}, {31'd0, v.exp_exc});
      checkOutput({tag, "_busy_at_rdy"}, {31'd0, bus_if.busy}, 32'd0);
      checkOutput({tag, "_hold"}, hold_bad, 32'd0);
      @(posedge clock); #1;
      checkOutput({tag, "_rdy_one_cycle"}, {31'd0, bus_if.data_resultRDY}, 32'd0);
   endtask

   vec_t vecs[18];

   initial begin
      int lat, hold_bad, rdy_seen;

      check_count = 0;
      pass_count  = 0;

      vecs[0]  = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, LAT_MUL};
      vecs[1]  = '{1'b0, 32'h00010000,  32'h00010000, 32'h00000000, 1'b1, LAT_MUL};
      vecs[2]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1, LAT_MUL};
      vecs[3]  = '{1'b0, 32'd6,         32'd7,        32'd42,       1'b0, LAT_MUL};
      vecs[4]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,        1'b0, LAT_MUL};
      vecs[5]  = '{1'b0, 32'h7FFFFFFF,  32'd2,        32'hFFFFFFFE, 1'b1, LAT_MUL};
      vecs[6]  = '{1'b0, 32'h80000000,  32'd1,        32'h80000000, 1'b0, LAT_MUL};
      vecs[7]  = '{1'b0, 32'd0,         32'd12345,    32'd0,        1'b0, LAT_MUL};
      vecs[8]  = '{1'b1, 32'hFFFFFFEF,  32'd5,        32'hFFFFFFFD, 1'b0, LAT_DIV};
      vecs[9]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1, LAT_DIV};
      vecs[10] = '{1'b1, 32'd100,       32'd0,        32'd0,        1'b1, LAT_DZ};
      vecs[11] = '{1'b1, 32'd100,       32'd7,        32'd14,       1'b0, LAT_DIV};
      vecs[12] = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, LAT_DIV};
      vecs[13] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF6, 32'd10,       1'b0, LAT_DIV};
      vecs[14] = '{1'b1, 32'd3,         32'd5,        32'd0,        1'b0, LAT_DIV};
      vecs[15] = '{1'b1, 32'hFFFFFFFF,  32'h80000000, 32'd0,        1'b0, LAT_DIV};
      vecs[16] = '{1'b1, 32'h80000000,  32'h80000000, 32'd1,        1'b0, LAT_DIV};
      vecs[17] = '{1'b1, 32'h7FFFFFFF,  32'd1,        32'h7FFFFFFF, 1'b0, LAT_DIV};

      bus_if.data_operandA = '0;
      bus_if.data_operandB = '0;
      bus_if.ctrl_MULT     = 1'b0;
      bus_if.ctrl_DIV      = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_result", bus_if.data_result, 32'd0);
      checkOutput("reset_exception", {31'd0, bus_if.data_exception}, 32'd0);
      checkOutput("reset_rdy", {31'd0, bus_if.data_resultRDY}, 32'd0);
      checkOutput("reset_busy", {31'd0, bus_if.busy}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;

      $display("[TB] running %0d table vectors", 18);
      for (int i = 0; i < 18; i++)
         runVector($sformatf("vec%0d", i), vecs[i], 0);

      // ctrl_DIV with a zero divisor at step 10 of a multiply must be ignored.
      runVector("mul_with_div_pulse", vecs[0], 10);

      // Reset at step 10 of a multiply: outputs clear at once, no RDY follows.
      bus_if.data_operandA = 32'd7;
      bus_if.data_operandB = 32'hFFFFFFFD;
      bus_if.ctrl_MULT     = 1'b1;
      @(posedge clock); #1;
      bus_if.ctrl_MULT = 1'b0;
      repeat (10) @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("midreset_result", bus_if.data_result, 32'd0);
      checkOutput("midreset_exception", {31'd0, bus_if.data_exception}, 32'd0);
      checkOutput("midreset_rdy", {31'd0, bus_if.data_resultRDY}, 32'd0);
      checkOutput("midreset_busy", {31'd0, bus_if.busy}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      rdy_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock); #1;
         if (bus_if.data_resultRDY || bus_if.busy) rdy_seen++;
      end
      checkOutput("midreset_no_rdy", rdy_seen, 32'd0);
      runVector("after_reset_6x7", vecs[3], 0);

      // Back-to-back: a multiply started in the RDY cycle of a divide.
      applyStimulus(1'b1, 32'hFFFFFFEF, 32'd5, 0, lat, hold_bad);
      checkOutput("b2b_div_latency", lat, LAT_DIV);
      checkOutput("b2b_div_result", bus_if.data_result, 32'hFFFFFFFD);
      applyStimulus(1'b0, 32'd6, 32'd7, 0, lat, hold_bad);
      checkOutput("b2b_mul_latency", lat, LAT_MUL);
      checkOutput("b2b_mul_result", bus_if.data_result, 32'd42);
      checkOutput("b2b_first_result_held", hold_bad, 32'd0);
      @(posedge clock); #1;
      checkOutput("b2b_rdy_one_cycle", {31'd0, bus_if.data_resultRDY}, 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
